// File: rtl/pcs_pkg.sv
// pcs_pkg: constants and types shared by the 40GbE PCS scrambler and descrambler.
//   SCR_LEN    length of the x^58 + x^39 + 1 history register
//   SCR_TAP_A  history index feeding the x^58 term
//   SCR_TAP_B  history index feeding the x^39 term
package pcs_pkg;

  localparam int unsigned SCR_LEN   = 58;
  localparam int unsigned SCR_TAP_A = 57;
  localparam int unsigned SCR_TAP_B = 38;

  typedef logic [SCR_LEN-1:0] scr_state_t;

  typedef enum logic {
    LOCK_UNSYNC = 1'b0,
    LOCK_SYNC   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/descramble_word.sv
// descramble_word: combinational self-synchronising descrambler for one beat.
//   data_in    scrambled payload, bit 0 first on the wire
//   hist       history (last 58 received bits, bit 0 most recent)
//   data_out   descrambled payload
//   next_hist  history after all DATA_W received bits have been shifted in
module descramble_word
  import pcs_pkg::*;
#(
  parameter int unsigned DATA_W = 256
) (
  input  logic [DATA_W-1:0] data_in,
  input  scr_state_t        hist,
  output logic [DATA_W-1:0] data_out,
  output scr_state_t        next_hist
);

  scr_state_t h;

  // The history shifts in the received (scrambled) bit, which is what
  // makes the descrambler self-synchronising.
  always_comb begin
    h        = hist;
    data_out = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      data_out[i] = data_in[i] ^ h[SCR_TAP_A] ^ h[SCR_TAP_B];
      h           = {h[SCR_LEN-2:0], data_in[i]};
    end
    next_hist = h;
  end

endmodule

// File: rtl/descrambler.sv
// descrambler: 40GbE PCS receive descrambler, single-stage valid/ready register.
//   clk, reset            clock; asynchronous active-high reset
//   clear                 synchronous resync: flush history and drop lock
//   in_valid/in_ready     input handshake; data_in payload, hdr_in sync headers
//   out_valid/out_ready   output handshake; data_out payload, hdr_out headers
//   out_ok                beat descrambled with fully valid history
//   locked                history holds at least 58 received bits
//   bypass                (only with DESCRAMBLER_BYPASS_EN) pass payload unmodified
// DATA_W must be at least 58.
module descrambler
  import pcs_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned HDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
`ifdef DESCRAMBLER_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [HDR_W-1:0]  hdr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [HDR_W-1:0]  hdr_out,
  output logic              out_ok,
  output logic              locked
);

  scr_state_t        hist;
  scr_state_t        next_hist;
  logic [DATA_W-1:0] descr;
  logic [DATA_W-1:0] out_next;
  lock_state_t       state;
  logic              fire;

  assign in_ready = !clear && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;

  descramble_word #(
    .DATA_W (DATA_W)
  ) u_word (
    .data_in   (data_in),
    .hist      (hist),
    .data_out  (descr),
    .next_hist (next_hist)
  );

  // In bypass the history still follows the received stream, so lock
  // survives a bypass window.
`ifdef DESCRAMBLER_BYPASS_EN
  assign out_next = bypass ? data_in : descr;
`else
  assign out_next = descr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOCK_UNSYNC;
      locked    <= 1'b0;
      hist      <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      hdr_out   <= '0;
      out_ok    <= 1'b0;
    end else if (clear) begin
      state     <= LOCK_UNSYNC;
      locked    <= 1'b0;
      hist      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (fire) begin
        hist      <= next_hist;
        out_valid <= 1'b1;
        data_out  <= out_next;
        hdr_out   <= hdr_in;
        out_ok    <= locked;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        LOCK_UNSYNC: begin
          if (fire) begin
            state  <= LOCK_SYNC;
            locked <= 1'b1;
          end
        end
        LOCK_SYNC: begin
          locked <= 1'b1;
        end
        default: begin
          state  <= LOCK_UNSYNC;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
